// File: rtl/fifo_sram_sched.sv
// Arbitrates a producer write stream and a consumer read stream onto a single-port SRAM FIFO,
// turning handshakes into one-cycle user pulses, merging opposite requests and watching for stalls.
module fifo_sram_sched #(
    parameter int DW      = 32,
    parameter int AVW     = 22,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_valid,
    input  logic [DW-1:0]  wr_data,
    output logic           wr_ready,
    input  logic           rd_req,
    output logic           rd_ack,
    output logic           rd_valid,
    output logic [DW-1:0]  rd_data,
    output logic           fifo_we,
    output logic           fifo_re,
    output logic [DW-1:0]  fifo_din,
    input  logic [DW-1:0]  fifo_dout,
    input  logic           fifo_rdy,
    input  logic           fifo_busy,
    input  logic           fifo_full,
    input  logic [AVW-1:0] fifo_avail,
    output logic           err_timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE, S_SETTLE} state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   timer;
    logic            wr_rec, rd_rec, rdy_seen;
    logic [DW-1:0]   din_q, rd_data_q;
    logic            rd_valid_q, err_q;

    logic            we_c, re_c, wr_ready_c, rd_ack_c;
    logic            capture, time_out, avail_nz, in_window;

    assign avail_nz  = |fifo_avail;
    assign in_window = (timer < TW'(2));

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        we_c       = 1'b0;
        re_c       = 1'b0;
        wr_ready_c = 1'b0;
        rd_ack_c   = 1'b0;
        capture    = 1'b0;
        time_out   = 1'b0;
        unique case (state)
            S_IDLE: begin
                wr_ready_c = !fifo_full && !fifo_busy;
                we_c       = wr_valid && wr_ready_c;
                rd_ack_c   = rd_req && !fifo_busy && (avail_nz || we_c);
                re_c       = rd_req && rd_ack_c;
                if (we_c || re_c)
                    state_nx = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Merge window: the opposite op may join only in the two cycles after issue.
                if (in_window) begin
                    if (!wr_rec && wr_valid && !fifo_full) begin
                        wr_ready_c = 1'b1;
                        we_c       = 1'b1;
                    end
                    if (!rd_rec && rd_req && (avail_nz || wr_rec || we_c)) begin
                        rd_ack_c = 1'b1;
                        re_c     = 1'b1;
                    end
                end
                if (timer == TW'(TIMEOUT - 1)) begin
                    time_out = 1'b1;
                    state_nx = S_SETTLE;
                end else if (fifo_busy) begin
                    state_nx = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (timer == TW'(TIMEOUT - 1)) begin
                    time_out = 1'b1;
                    state_nx = S_SETTLE;
                end else begin
                    capture = rd_rec && fifo_rdy && !rdy_seen;
                    if (!fifo_busy && (!rd_rec || rdy_seen || fifo_rdy))
                        state_nx = S_SETTLE;
                end
            end
            S_SETTLE: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Combinational handshakes are forced low while reset is held so every output reads 0.
    assign wr_ready    = rst_n && wr_ready_c;
    assign rd_ack      = rst_n && rd_ack_c;
    assign fifo_we     = rst_n && we_c;
    assign fifo_re     = rst_n && re_c;
    assign fifo_din    = din_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign err_timeout = err_q;

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            wr_rec     <= 1'b0;
            rd_rec     <= 1'b0;
            rdy_seen   <= 1'b0;
            din_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                timer <= '0;
            else if (state == S_WAIT_BUSY || state == S_WAIT_DONE)
                timer <= timer + 1'b1;

            if (state == S_IDLE) begin
                wr_rec   <= we_c;
                rd_rec   <= re_c;
                rdy_seen <= 1'b0;
            end else begin
                if (we_c)    wr_rec   <= 1'b1;
                if (re_c)    rd_rec   <= 1'b1;
                if (capture) rdy_seen <= 1'b1;
            end

            if (we_c)     din_q     <= wr_data;
            if (capture)  rd_data_q <= fifo_dout;
            rd_valid_q <= capture;
            if (time_out) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_sram_sched.sv
// Directed bench for fifo_sram_sched: a small behavioural SRAM FIFO answers the scheduler's pulses,
// and each step compares outputs against hand-computed values with immediate assertions.
module tb_fifo_sram_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        rd_req = 1'b0;
    logic        rd_ack;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        fifo_we, fifo_re;
    logic [31:0] fifo_din, fifo_dout;
    logic        fifo_rdy, fifo_busy, fifo_full;
    logic [21:0] fifo_avail;
    logic        err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_sram_sched dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_din(fifo_din), .fifo_dout(fifo_dout),
        .fifo_rdy(fifo_rdy), .fifo_busy(fifo_busy), .fifo_full(fifo_full),
        .fifo_avail(fifo_avail), .err_timeout(err_timeout)
    );

    // FIFO model: an op starts on the first pulse; busy for op cycles 2..4, write lands at
    // the end of cycle 2, read data is presented with fifo_rdy in cycle 4, idle after cycle 5.
    logic        m_stall = 1'b0;
    logic        m_active, m_w, m_r;
    int          m_cnt, m_wp, m_rp, m_count;
    logic [31:0] m_mem [16];

    assign fifo_busy  = m_active && m_cnt >= 2 && m_cnt <= 4;
    assign fifo_rdy   = m_active && m_r && m_cnt == 4;
    assign fifo_dout  = m_mem[m_rp];
    assign fifo_avail = 22'(m_count);
    assign fifo_full  = (m_count == 16);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_cnt <= 0; m_w <= 1'b0; m_r <= 1'b0;
            m_wp <= 0; m_rp <= 0; m_count <= 0;
        end else if (!m_active) begin
            if ((fifo_we || fifo_re) && !m_stall) begin
                m_active <= 1'b1; m_cnt <= 0; m_w <= fifo_we; m_r <= fifo_re;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (fifo_we) m_w <= 1'b1;
            if (fifo_re) m_r <= 1'b1;
            if (m_cnt == 2 && m_w) begin
                m_mem[m_wp] <= fifo_din; m_wp <= (m_wp + 1) % 16; m_count <= m_count + 1;
            end
            if (m_cnt == 4 && m_r) begin
                m_rp <= (m_rp + 1) % 16; m_count <= m_count - 1;
            end
            if (m_cnt == 5) m_active <= 1'b0;
        end
    end

    // Free-running pulse counters; steps compare deltas against snapshots.
    int n_we = 0, n_re = 0, n_rv = 0, n_ack = 0;
    always @(posedge clk) begin
        if (fifo_we)  n_we++;
        if (fifo_re)  n_re++;
        if (rd_valid) n_rv++;
        if (rd_ack)   n_ack++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        wr_valid = 1'b0; rd_req = 1'b0; m_stall = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        #1;
    endtask

    int b_we, b_re, b_rv, b_ack, bad_rdy, bad_din;

    initial begin
        // Reset state
        tick(2);
        check("rst_outputs", {wr_ready, rd_ack, rd_valid, fifo_we, fifo_re, err_timeout}, 6'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_fifo_din", fifo_din, 32'h0);
        rst_n = 1'b1;
        #1;
        check("idle_wr_ready", wr_ready, 1'b1);

        // 1: single write into an empty FIFO
        b_we = n_we;
        wr_valid = 1'b1; wr_data = 32'hDEADBEEF;
        #1;
        check("t1_issue", {wr_ready, fifo_we, fifo_re}, 3'b110);
        tick();
        wr_valid = 1'b0;
        bad_rdy = 0; bad_din = 0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            if (wr_ready !== 1'b0) bad_rdy++;
            if (fifo_din !== 32'hDEADBEEF) bad_din++;
            tick();
        end
        check("t1_wr_ready_low", bad_rdy, 0);
        check("t1_din_stable", bad_din, 0);
        check("t1_back_idle", wr_ready, 1'b1);
        check("t1_we_count", n_we - b_we, 1);
        check("t1_avail", fifo_avail, 22'd1);

        // 2: write 0x1, read joins at T+1
        do_reset();
        b_we = n_we; b_re = n_re; b_rv = n_rv;
        wr_valid = 1'b1; wr_data = 32'h1;
        #1;
        check("t2_issue_we", fifo_we, 1'b1);
        tick();
        wr_valid = 1'b0; rd_req = 1'b1;
        #1;
        check("t2_merge_re", {rd_ack, fifo_re}, 2'b11);
        tick();
        rd_req = 1'b0;
        tick(12);
        check("t2_rd_valid_count", n_rv - b_rv, 1);
        check("t2_rd_data", rd_data, 32'h1);
        check("t2_we_count", n_we - b_we, 1);
        check("t2_re_count", n_re - b_re, 1);

        // 3: read on empty FIFO waits until a write arrives
        do_reset();
        b_re = n_re; b_ack = n_ack; b_rv = n_rv;
        rd_req = 1'b1;
        tick(100);
        check("t3_no_ack", n_ack - b_ack, 0);
        check("t3_no_re", n_re - b_re, 0);
        wr_valid = 1'b1; wr_data = 32'hA5A5A5A5;
        #1;
        check("t3_combined", {rd_ack, fifo_we, fifo_re}, 3'b111);
        tick();
        wr_valid = 1'b0; rd_req = 1'b0;
        tick(12);
        check("t3_rd_valid_count", n_rv - b_rv, 1);
        check("t3_rd_data", rd_data, 32'hA5A5A5A5);

        // 4: simultaneous write and read on empty FIFO
        do_reset();
        b_we = n_we; b_re = n_re;
        wr_valid = 1'b1; wr_data = 32'h12345678; rd_req = 1'b1;
        #1;
        check("t4_same_cycle", {fifo_we, fifo_re}, 2'b11);
        tick();
        wr_valid = 1'b0; rd_req = 1'b0;
        tick(12);
        check("t4_rd_data", rd_data, 32'h12345678);
        check("t4_pulses", {n_we - b_we, n_re - b_re}, {32'd1, 32'd1});

        // 5: FIFO never raises busy -> timeout
        do_reset();
        m_stall = 1'b1;
        b_rv = n_rv;
        wr_valid = 1'b1; wr_data = 32'h55; rd_req = 1'b1;
        #1;
        check("t5_issue", {fifo_we, fifo_re}, 2'b11);
        tick();
        wr_valid = 1'b0; rd_req = 1'b0;
        tick(63);
        check("t5_err_before", err_timeout, 1'b0);
        tick();
        check("t5_err_set", {err_timeout, wr_ready}, 2'b10);
        tick();
        check("t5_idle", wr_ready, 1'b1);
        check("t5_no_rd_valid", n_rv - b_rv, 0);
        m_stall = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h99;
        #1;
        check("t5_not_blocked", fifo_we, 1'b1);
        tick();
        wr_valid = 1'b0;
        tick(8);
        check("t5_err_sticky", err_timeout, 1'b1);

        // 6: reset during S_WAIT_DONE of a read
        do_reset();
        wr_valid = 1'b1; wr_data = 32'h77;
        tick();
        wr_valid = 1'b0;
        tick(7);
        wr_valid = 1'b1; wr_data = 32'h88;
        tick();
        wr_valid = 1'b0;
        tick(7);
        rd_req = 1'b1;
        #1;
        check("t6_first_ack", rd_ack, 1'b1);
        tick();
        rd_req = 1'b0;
        tick(7);
        check("t6_first_data", rd_data, 32'h77);
        rd_req = 1'b1;
        #1;
        check("t6_second_ack", rd_ack, 1'b1);
        tick();
        rd_req = 1'b0;
        tick(3);
        b_rv = n_rv;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {wr_ready, rd_ack, rd_valid, fifo_we, fifo_re, err_timeout}, 6'b0);
        check("t6_rst_data", {rd_data, fifo_din}, 64'h0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("t6_no_rd_valid", n_rv - b_rv, 0);
        check("t6_idle_after", wr_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
